div_unit: RTL and testbench
===========================

# div_unit

Iterative RV32M divider (DIV, DIVU, REM, REMU) in the execute stage. It is the requesting side of the pipeline stall protocol. While a division is in flight it drives a stall request into the hazard logic, which freezes fetch, decode and execute. It releases the request in the single cycle its result is presented, so the divide instruction leaves execute with its result in that same cycle.

## Interface
Parameters:
- XLEN, 32, operand/result width; counter width is $clog2(XLEN)+1

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- e_start  in  1  execute-stage instruction is a valid divide/remainder op
- e_funct3  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- e_op_a  in  XLEN  dividend (rs1 value after forwarding)
- e_op_b  in  XLEN  divisor (rs2 value after forwarding)
- kill  in  1  synchronous abort of any operation in flight (exception/trap flush)
- stall_req  out  1  combinational request to stall F/D/E and flush ID/EX bubble
- busy  out  1  registered, high in CALC and DONE
- result  out  XLEN  quotient or remainder, registered
- result_valid  out  1  registered, one-cycle strobe coinciding with DONE

## Operation
- States: IDLE, CALC, DONE. Reset -> IDLE. Reset values: result=0, result_valid=0, busy=0, counter=0, internal registers 0.
- IDLE, e_start=1, kill=0:
  - Latch the operation and the operand signs, plus magnitude operands: absolute values for signed ops, raw values for unsigned ops.
  - Divisor==0: quotient=all ones, remainder=e_op_a; go to DONE.
  - Signed op with e_op_a=0x8000_0000 (XLEN MSB only) and e_op_b=all ones: quotient=e_op_a, remainder=0; go to DONE.
  - Otherwise load counter=XLEN and go to CALC.
- CALC: restoring radix-2 division, one quotient bit per cycle.
  - Partial remainder is XLEN+1 bits. Shift in the dividend MSB, then trial-subtract the divisor.
  - Non-negative trial: keep the difference and set q bit 1. Negative trial: restore and set q bit 0.
  - Decrement counter each cycle. When the counter reaches 1 on this cycle's step, go to DONE.
- DONE: present the final value, then return to IDLE unconditionally.
  - Sign fix for signed ops: quotient is negated iff the operand signs differ and divisor!=0; remainder takes the sign of the dividend.
  - REM/REMU select the remainder, DIV/DIVU select the quotient.
  - All arithmetic is modulo 2^XLEN.
- stall_req = ~kill & ((IDLE & e_start) | CALC). It is 0 in DONE, so the held instruction advances with result_valid=1.
- e_start is ignored in DONE. The same instruction is still visible there and must not restart. The next divide is accepted in the following IDLE cycle.
- kill has priority in every state:
  - Next state is IDLE and the pending result is discarded (result_valid stays 0).
  - stall_req drops in the same cycle.
  - result holds its previous value.
- Asynchronous reset mid-operation: immediate return to IDLE with all reset values; no result is produced.

## Timing
- Start accepted in cycle T (IDLE, e_start=1).
- Normal op: CALC in cycles T+1..T+XLEN, DONE in T+XLEN+1. stall_req is high for XLEN+1 cycles (T..T+XLEN); result_valid=1 only in T+XLEN+1.
- Special case (divide by zero or signed overflow): DONE in T+1, stall_req high in T only.
- busy rises in the cycle after the start is accepted and falls in the cycle after DONE.
- Back-to-back divides: the second is accepted at T+XLEN+2 at the earliest (T+2 for special cases).
- result is stable from DONE until the next DONE or reset.
- No combinational path from e_op_a or e_op_b to any output. stall_req depends only on state, e_start and kill.

## Test plan
- DIVU 100/7, XLEN=32: stall_req high 33 cycles, then result_valid with result=14. Repeat with REMU: result=2.
- DIV -7/2 -> result=0xFFFF_FFFD (-3). REM -7/2 -> 0xFFFF_FFFF (-1). REM 7/-2 -> 1.
- DIV 5/0 -> 0xFFFF_FFFF with stall_req for exactly 1 cycle and result_valid on the next cycle. REM 5/0 -> 5.
- DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000 and REM -> 0. DIVU on the same operands takes 33 stall cycles and returns 0.
- kill at the 10th CALC cycle: stall_req=0 in that cycle, no result_valid ever. A new DIVU 9/3 started 1 cycle later returns 3.
- rst_n low mid-CALC: outputs are 0 immediately. After release, a DIVU 8/2 returns 4 with full latency.

Source files
------------

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) for the execute stage.
// Holds the pipeline through stall_req while a quotient is being formed and
// releases it in the cycle the registered result is presented.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for e_start; special cases resolve directly to DONE
//   S_CALC | one restoring quotient bit per cycle, r_cnt counts down
//   S_DONE | result/result_valid presented, stall released, back to IDLE
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            e_start,
    input  logic [1:0]      e_funct3,
    input  logic [XLEN-1:0] e_op_a,
    input  logic [XLEN-1:0] e_op_b,
    input  logic            kill,
    output logic            stall_req,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvsr;
    logic            r_is_rem;
    logic            r_neg_q;
    logic            r_neg_r;

    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_div_zero;
    logic            w_ovf;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_trial;
    logic            w_qbit;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;
    logic [XLEN-1:0] w_final;

    // Operand decode at issue: magnitudes for signed ops, raw for unsigned
    assign w_signed   = ~e_funct3[0];
    assign w_a_neg    = w_signed & e_op_a[XLEN-1];
    assign w_b_neg    = w_signed & e_op_b[XLEN-1];
    assign w_abs_a    = w_a_neg ? -e_op_a : e_op_a;
    assign w_abs_b    = w_b_neg ? -e_op_b : e_op_b;
    assign w_div_zero = (e_op_b == '0);
    assign w_ovf      = w_signed & (e_op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&e_op_b);

    // Restoring step: shift in next dividend bit, trial-subtract divisor.
    // The kept remainder is always below the divisor, so XLEN bits suffice.
    assign w_shift   = {r_rem, r_quo[XLEN-1]};
    assign w_trial   = w_shift - {1'b0, r_dvsr};
    assign w_qbit    = ~w_trial[XLEN];
    assign w_rem_nxt = w_qbit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_quo_nxt = {r_quo[XLEN-2:0], w_qbit};

    // Sign fix-up on the final step; divisor is nonzero whenever CALC runs
    assign w_q_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_r_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    assign w_final = r_is_rem ? w_r_fix : w_q_fix;

    // Stall covers the accept cycle and all of CALC; DONE lets the op retire
    assign stall_req = ~kill & (((r_state == S_IDLE) & e_start) | (r_state == S_CALC));

    // Divider FSM with registered result, strobe and busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_dvsr       <= '0;
            r_is_rem     <= 1'b0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (kill) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (e_start) begin
                            r_is_rem <= e_funct3[1];
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_quo    <= w_abs_a;
                            r_dvsr   <= w_abs_b;
                            r_rem    <= '0;
                            busy     <= 1'b1;
                            if (w_div_zero) begin
                                result       <= e_funct3[1] ? e_op_a : {XLEN{1'b1}};
                                result_valid <= 1'b1;
                                r_state      <= S_DONE;
                            end else if (w_ovf) begin
                                result       <= e_funct3[1] ? '0 : e_op_a;
                                result_valid <= 1'b1;
                                r_state      <= S_DONE;
                            end else begin
                                r_cnt   <= CW'(XLEN);
                                r_state <= S_CALC;
                            end
                        end
                    end
                    S_CALC: begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CW'(1)) begin
                            result       <= w_final;
                            result_valid <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver pushes hand-computed results,
// an independent monitor pops and compares on every result_valid.
module tb_div_unit;
    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            e_start;
    logic [1:0]      e_funct3;
    logic [XLEN-1:0] e_op_a;
    logic [XLEN-1:0] e_op_b;
    logic            kill;
    logic            stall_req;
    logic            busy;
    logic [XLEN-1:0] result;
    logic            result_valid;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] last_res = '0;

    localparam logic [1:0] F_DIV = 2'b00, F_DIVU = 2'b01, F_REM = 2'b10, F_REMU = 2'b11;

    div_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .e_start(e_start), .e_funct3(e_funct3),
        .e_op_a(e_op_a), .e_op_b(e_op_b), .kill(kill), .stall_req(stall_req),
        .busy(busy), .result(result), .result_valid(result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every presented result must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got result 0x%08h with no pending op", result);
            end else begin
                last_res = exp_q.pop_front();
                check("result", result, last_res);
                check("stall_in_done", {31'd0, stall_req}, 32'd0);
                check("busy_in_done", {31'd0, busy}, 32'd1);
            end
        end
    end

    // Present an op in execute starting at the next falling edge
    task automatic start_op(input logic [1:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        @(negedge clk);
        e_start  = 1'b1;
        e_funct3 = f3;
        e_op_a   = a;
        e_op_b   = b;
    endtask

    // Hold the instruction in execute while stalled; it retires when stall drops
    task automatic issue(input string name, input logic [1:0] f3, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int exp_stall);
        int n;
        bit done;
        start_op(f3, a, b);
        exp_q.push_back(exp);
        n = 0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            if (stall_req) begin
                n++;
                @(negedge clk);
            end else begin
                done = 1;
            end
        end
        check({name, "_stall_cycles"}, n, exp_stall);
        @(negedge clk);
        e_start = 1'b0;
        #1;
        check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        e_start  = 1'b0;
        e_funct3 = 2'b00;
        e_op_a   = '0;
        e_op_b   = '0;
        kill     = 1'b0;
        #1;
        check("reset_result", result, 32'd0);
        check("reset_valid", {31'd0, result_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_stall", {31'd0, stall_req}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue("divu_100_7",   F_DIVU, 32'd100, 32'd7, 32'd14, 33);
        issue("remu_100_7",   F_REMU, 32'd100, 32'd7, 32'd2, 33);
        issue("div_m7_2",     F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        issue("rem_m7_2",     F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        issue("rem_7_m2",     F_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        issue("div_m7_m2",    F_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 33);
        issue("divu_max_1",   F_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
        issue("div_5_0",      F_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        issue("rem_5_0",      F_REM,  32'd5, 32'd0, 32'd5, 1);
        issue("divu_5_0",     F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        issue("div_ovf",      F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue("rem_ovf",      F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        issue("divu_ovf_ops", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

        // Kill on the 10th CALC cycle: stall drops at once, no result ever
        start_op(F_DIVU, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        kill    = 1'b1;
        e_start = 1'b0;
        #1;
        check("kill_stall", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        kill = 1'b0;
        #1;
        check("kill_busy", {31'd0, busy}, 32'd0);
        check("kill_result_held", result, last_res);
        issue("divu_9_3", F_DIVU, 32'd9, 32'd3, 32'd3, 33);

        // Async reset mid-CALC clears outputs immediately
        start_op(F_DIVU, 32'd77, 32'd5);
        repeat (5) @(negedge clk);
        rst_n   = 1'b0;
        e_start = 1'b0;
        #1;
        check("rst_mid_result", result, 32'd0);
        check("rst_mid_valid", {31'd0, result_valid}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_stall", {31'd0, stall_req}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue("divu_8_2", F_DIVU, 32'd8, 32'd2, 32'd4, 33);

        repeat (40) @(negedge clk);
        check("pending_left", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
